// File: rtl/accum_relu.sv
// -----------------------------------------------------------------------------
// accum_relu
//
// Channel accumulator and activation stage ahead of the pool block. For one
// output channel it receives a partial sum per pixel per input channel in
// raster order, accumulates them across input channels in an on-chip buffer,
// and on the final input channel adds the bias, applies ReLU, saturates to
// DWIDTH and emits the pixel with out_en.
//
// Ports
//   clk        rising-edge clock
//   xrst       asynchronous active-low reset
//   start      one-cycle pulse, begins an output channel (ignored while busy)
//   img_size   pixels per map (1..MAXPIX), sampled on start
//   num_chan   input channels (1..2^CWIDTH-1), sampled on start
//   bias       signed bias, sampled on start
//   in_valid   pixel_in valid this cycle (honoured only while accumulating)
//   pixel_in   signed partial sum
//   busy       channel in progress
//   out_en     pixel_out valid
//   pixel_out  activated, saturated pixel
//   done       one-cycle pulse together with the final out_en
//
// Pipeline: stage 0 accepts a pixel and issues the buffer read, stage 1 forms
// the running sum and writes it back, stage 2 registers the activated output.
// -----------------------------------------------------------------------------
module accum_relu #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 24,
    parameter int PWIDTH = 10,
    parameter int CWIDTH = 8,
    parameter int MAXPIX = 784
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              start,
    input  logic [PWIDTH-1:0] img_size,
    input  logic [CWIDTH-1:0] num_chan,
    input  logic [DWIDTH-1:0] bias,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] pixel_in,
    output logic              busy,
    output logic              out_en,
    output logic [DWIDTH-1:0] pixel_out,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Largest positive DWIDTH value, widened to the final-sum width.
    localparam logic [AWIDTH:0]   POS_MAX_WIDE = {{(AWIDTH+2-DWIDTH){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] POS_MAX      = {1'b0, {(DWIDTH-1){1'b1}}};

    // ---------------------------------------------------------------- state
    state_e            state_q, state_d;
    logic [PWIDTH-1:0] img_size_q, img_size_d;
    logic [CWIDTH-1:0] num_chan_q, num_chan_d;
    logic [DWIDTH-1:0] bias_q, bias_d;
    logic [PWIDTH-1:0] pcnt_q, pcnt_d;
    logic [CWIDTH-1:0] ccnt_q, ccnt_d;
    logic              drain_q, drain_d;
    logic              busy_q, busy_d;

    // Stage 1 (sum / write-back)
    logic              s1_valid_q, s1_valid_d;
    logic [PWIDTH-1:0] s1_addr_q, s1_addr_d;
    logic              s1_first_q, s1_first_d;
    logic              s1_out_q, s1_out_d;
    logic              s1_done_q, s1_done_d;
    logic [DWIDTH-1:0] s1_pix_q, s1_pix_d;
    logic              s1_byp_q, s1_byp_d;
    logic [AWIDTH-1:0] s1_byp_data_q, s1_byp_data_d;

    // Stage 2 (registered outputs)
    logic              out_en_q, out_en_d;
    logic [DWIDTH-1:0] pixel_out_q, pixel_out_d;
    logic              done_q, done_d;

    // Accumulation buffer
    logic [AWIDTH-1:0] acc_mem [MAXPIX];
    logic [AWIDTH-1:0] ram_rd_q;

    // ---------------------------------------------------------------- datapath
    logic              accept;
    logic              last_pix;
    logic              last_chan;
    logic [AWIDTH-1:0] acc_base;
    logic [AWIDTH-1:0] sum;
    logic [AWIDTH:0]   final_sum;
    logic [DWIDTH-1:0] activated;

    assign accept    = (state_q == ACC) && in_valid;
    assign last_pix  = (pcnt_q == img_size_q - PWIDTH'(1));
    assign last_chan = (ccnt_q == num_chan_q - CWIDTH'(1));

    always_comb begin
        // The first input channel never looks at the buffer, so stale contents
        // (earlier channels, power-up garbage) cannot leak into the result.
        // A same-address write in the previous cycle is taken from the bypass
        // register because the synchronous read returned the pre-write value.
        if (s1_first_q) begin
            acc_base = '0;
        end else if (s1_byp_q) begin
            acc_base = s1_byp_data_q;
        end else begin
            acc_base = ram_rd_q;
        end
        sum       = acc_base + {{(AWIDTH-DWIDTH){s1_pix_q[DWIDTH-1]}}, s1_pix_q};
        final_sum = {sum[AWIDTH-1], sum} + {{(AWIDTH+1-DWIDTH){bias_q[DWIDTH-1]}}, bias_q};
        if (final_sum[AWIDTH]) begin
            activated = '0;
        end else if (final_sum > POS_MAX_WIDE) begin
            activated = POS_MAX;
        end else begin
            activated = final_sum[DWIDTH-1:0];
        end
    end

    // ---------------------------------------------------------------- control
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        img_size_d = img_size_q;
        num_chan_d = num_chan_q;
        bias_d     = bias_q;
        pcnt_d     = pcnt_q;
        ccnt_d     = ccnt_q;
        drain_d    = drain_q;
        busy_d     = busy_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACC;
                    img_size_d = img_size;
                    num_chan_d = num_chan;
                    bias_d     = bias;
                    pcnt_d     = '0;
                    ccnt_d     = '0;
                    busy_d     = 1'b1;
                end
            end
            ACC: begin
                if (accept) begin
                    if (last_pix) begin
                        pcnt_d = '0;
                        if (last_chan) begin
                            state_d = DRAIN;
                            drain_d = 1'b0;
                        end else begin
                            ccnt_d = ccnt_q + CWIDTH'(1);
                        end
                    end else begin
                        pcnt_d = pcnt_q + PWIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                // Two cycles: the last pixel passes stage 1, then stage 2.
                if (drain_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        s1_valid_d    = accept;
        s1_addr_d     = pcnt_q;
        s1_first_d    = (ccnt_q == '0);
        s1_out_d      = last_chan;
        s1_done_d     = last_chan && last_pix;
        s1_pix_d      = pixel_in;
        s1_byp_d      = accept && s1_valid_q && (s1_addr_q == pcnt_q);
        s1_byp_data_d = sum;

        out_en_d    = s1_valid_q && s1_out_q;
        done_d      = s1_valid_q && s1_done_q;
        pixel_out_d = out_en_d ? activated : pixel_out_q;
    end

    // ---------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q       <= IDLE;
            img_size_q    <= '0;
            num_chan_q    <= '0;
            bias_q        <= '0;
            pcnt_q        <= '0;
            ccnt_q        <= '0;
            drain_q       <= 1'b0;
            busy_q        <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_addr_q     <= '0;
            s1_first_q    <= 1'b0;
            s1_out_q      <= 1'b0;
            s1_done_q     <= 1'b0;
            s1_pix_q      <= '0;
            s1_byp_q      <= 1'b0;
            s1_byp_data_q <= '0;
            out_en_q      <= 1'b0;
            pixel_out_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            img_size_q    <= img_size_d;
            num_chan_q    <= num_chan_d;
            bias_q        <= bias_d;
            pcnt_q        <= pcnt_d;
            ccnt_q        <= ccnt_d;
            drain_q       <= drain_d;
            busy_q        <= busy_d;
            s1_valid_q    <= s1_valid_d;
            s1_addr_q     <= s1_addr_d;
            s1_first_q    <= s1_first_d;
            s1_out_q      <= s1_out_d;
            s1_done_q     <= s1_done_d;
            s1_pix_q      <= s1_pix_d;
            s1_byp_q      <= s1_byp_d;
            s1_byp_data_q <= s1_byp_data_d;
            out_en_q      <= out_en_d;
            pixel_out_q   <= pixel_out_d;
            done_q        <= done_d;
        end
    end

    // NOTE: the buffer has no reset so it maps onto block RAM; correctness
    // relies on channel 0 ignoring the read data instead.
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            acc_mem[s1_addr_q] <= sum;
        end
        if (accept) begin
            ram_rd_q <= acc_mem[pcnt_q];
        end
    end

    assign busy      = busy_q;
    assign out_en    = out_en_q;
    assign pixel_out = pixel_out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_accum_relu.sv
// -----------------------------------------------------------------------------
// tb_accum_relu
//
// Stimulus pushes the expected activated pixel (value, done flag, cycle) into
// a queue as each final-channel pixel is issued; an independent monitor pops
// and compares whenever the DUT presents out_en or done. Expected values come
// from a per-pixel running sum over channels with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_accum_relu;

    logic        clk;
    logic        xrst;
    logic        start;
    logic [9:0]  img_size;
    logic [7:0]  num_chan;
    logic [15:0] bias;
    logic        in_valid;
    logic [15:0] pixel_in;
    logic        busy;
    logic        out_en;
    logic [15:0] pixel_out;
    logic        done;

    accum_relu dut (
        .clk       (clk),
        .xrst      (xrst),
        .start     (start),
        .img_size  (img_size),
        .num_chan  (num_chan),
        .bias      (bias),
        .in_valid  (in_valid),
        .pixel_in  (pixel_in),
        .busy      (busy),
        .out_en    (out_en),
        .pixel_out (pixel_out),
        .done      (done)
    );

    typedef struct {
        logic [15:0] pix;
        logic        last;
        longint      cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] pix_list[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic longint wrap24(input longint v);
        logic [23:0] w;
        w = v[23:0];
        return longint'($signed(w));
    endfunction

    function automatic logic [15:0] activate(input longint acc, input logic [15:0] b);
        longint t;
        t = acc + longint'($signed(b));
        if (t < 0) return 16'h0000;
        if (t > 32767) return 16'h7FFF;
        return t[15:0];
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (xrst) begin
                if (prev_done) check("busy_after_done", busy, 1'b0);
                if (out_en || done) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got out_en=%0b done=%0b pixel=0x%0h, expected no output",
                                 out_en, done, pixel_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_en", out_en, 1'b1);
                        check("pixel_out", pixel_out, e.pix);
                        check("done_flag", done, e.last);
                        check("latency_cycle", cyc, e.cyc);
                        if (done) check("busy_during_done", busy, 1'b1);
                    end
                end
                prev_done = done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", busy, 1'b0);
    endtask

    task automatic run_chan(input int size, input int nch, input logic [15:0] b, input bit gaps);
        longint acc[];
        int     idx;
        exp_t   e;
        acc = new[size];
        foreach (acc[i]) acc[i] = 0;
        idx = 0;
        wait_idle();
        if (gaps) begin
            repeat (3) begin
                @(negedge clk);
                in_valid = 1'b1;
                pixel_in = 16'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        img_size = 10'(size);
        num_chan = 8'(nch);
        bias     = b;
        for (int c = 0; c < nch; c++) begin
            for (int p = 0; p < size; p++) begin
                if (gaps) begin
                    while ($urandom_range(0, 2) == 0) begin
                        @(negedge clk);
                        start    = 1'b0;
                        in_valid = 1'b0;
                        pixel_in = 16'($urandom);
                        if ($urandom_range(0, 3) == 0) begin
                            start    = 1'b1;
                            img_size = 10'($urandom_range(1, 5));
                            num_chan = 8'($urandom_range(1, 5));
                            bias     = 16'($urandom);
                        end
                    end
                end
                @(negedge clk);
                start    = 1'b0;
                in_valid = 1'b1;
                pixel_in = pix_list[idx];
                idx++;
                acc[p] = wrap24(acc[p] + longint'($signed(pixel_in)));
                if (c == nch - 1) begin
                    e.pix  = activate(acc[p], b);
                    e.last = (p == size - 1);
                    e.cyc  = cyc + 2;
                    exp_q.push_back(e);
                end
            end
        end
        @(negedge clk);
        in_valid = gaps;
        pixel_in = 16'($urandom);
        start    = gaps;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic fill_const(input int n, input logic [15:0] v);
        pix_list.delete();
        repeat (n) pix_list.push_back(v);
    endtask

    task automatic fill_rand(input int n);
        pix_list.delete();
        repeat (n) pix_list.push_back(16'($urandom));
    endtask

    initial begin
        int          sz;
        int          nc;
        logic [15:0] b;

        xrst     = 1'b0;
        start    = 1'b0;
        img_size = '0;
        num_chan = '0;
        bias     = '0;
        in_valid = 1'b0;
        pixel_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_out_en", out_en, 1'b0);
        check("reset_pixel_out", pixel_out, 16'h0000);
        check("reset_done", done, 1'b0);
        xrst = 1'b1;
        @(negedge clk);

        // Single channel with ReLU clamp and positive saturation.
        pix_list = {16'h0100, 16'hFF00, 16'h7FF0, 16'h0000};
        run_chan(4, 1, 16'h0010, 1'b0);

        // Accumulation over three channels.
        fill_const(9, 16'h0005);
        run_chan(3, 3, 16'h0000, 1'b0);

        // Single-pixel map: every access hits the same address back to back.
        pix_list = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
        run_chan(1, 4, 16'h0000, 1'b0);

        // Stale buffer contents must not leak into a new channel.
        fill_const(8, 16'h1000);
        run_chan(4, 2, 16'h0000, 1'b0);
        fill_const(4, 16'h0001);
        run_chan(4, 1, 16'h0000, 1'b0);

        // Random maps, each run gap-free and then with bubbles and ignored
        // start / in_valid pulses.
        for (int r = 0; r < 6; r++) begin
            sz = (r == 0) ? 1 : $urandom_range(1, 12);
            nc = $urandom_range(1, 5);
            b  = 16'($urandom);
            fill_rand(sz * nc);
            run_chan(sz, nc, b, 1'b0);
            run_chan(sz, nc, b, 1'b1);
        end

        // Full-depth map.
        fill_rand(784 * 2);
        run_chan(784, 2, 16'h0040, 1'b0);

        // Reset in the middle of a channel.
        wait_idle();
        @(negedge clk);
        start    = 1'b1;
        img_size = 10'd4;
        num_chan = 8'd1;
        bias     = 16'h0000;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        pixel_in = 16'h0011;
        @(negedge clk);
        pixel_in = 16'h0022;
        @(posedge clk);
        #1;
        xrst     = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midreset_busy", busy, 1'b0);
        check("midreset_out_en", out_en, 1'b0);
        check("midreset_pixel_out", pixel_out, 16'h0000);
        check("midreset_done", done, 1'b0);
        exp_q.delete();
        @(negedge clk);
        xrst = 1'b1;
        pix_list = {16'h0021, 16'h0FFF, 16'h8000, 16'h0003};
        run_chan(4, 1, 16'h0002, 1'b0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
